// File: rtl/burst_seq_pkg.sv
// Shared types for the burst sequencer: command record, FSM states, widths.
package burst_seq_pkg;

    localparam int CMD_TIME_W = 64;
    localparam int CMD_FREQ_W = 48;
    localparam int CMD_RATE_W = 32;
    localparam int CMD_IVL_W  = 32;
    localparam int CMD_NIMP_W = 16;

    // One queued burst command, exactly as written by the command register.
    typedef struct packed {
        logic [CMD_TIME_W-1:0] start;
        logic [CMD_FREQ_W-1:0] freq;
        logic [CMD_FREQ_W-1:0] dfreq;
        logic [CMD_RATE_W-1:0] rate;
        logic [CMD_NIMP_W-1:0] nimp;
        logic                  coh;
        logic [CMD_IVL_W-1:0]  tb1;
        logic [CMD_IVL_W-1:0]  ti;
        logic [CMD_IVL_W-1:0]  tb2;
        logic [CMD_IVL_W-1:0]  tp;
    } cmd_t;

    typedef enum logic [3:0] {
        S_IDLE, S_WAIT_T, S_LOAD, S_ACKWAIT, S_BLANK1, S_TIZL, S_BLANK2, S_TPR, S_NEXT
    } state_t;

    // Down-counter preset so an interval of N lasts N cycles; 0 behaves as 1.
    function automatic logic [CMD_IVL_W-1:0] ivl_load(input logic [CMD_IVL_W-1:0] n);
        return (n == '0) ? '0 : n - 1'b1;
    endfunction

endpackage

// File: rtl/burst_cmd_fifo.sv
// Synchronous command FIFO with flush, level and overflow pulse.
module burst_cmd_fifo
    import burst_seq_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   flush,
    input  logic                   wr,
    input  cmd_t                   wdata,
    input  logic                   rd,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf
);
    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = rd && !empty && !flush;
    // A pop in the same cycle frees a slot, so a push into a full FIFO survives it.
    assign do_push = wr && !flush && (!full || do_pop);
    assign rdata   = mem[rp];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge CLK) begin
        if (do_push) mem[wp] <= wdata;
    end

    // Pointers, occupancy and overflow pulse; pointers wrap naturally at DEPTH.
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            ovf <= wr && !do_push;
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/burst_sequencer.sv
// Time-triggered burst sequencer: pops timed commands and runs
// blank1 / emit / blank2 / receive pulses with a 4-phase DDS load.
// Field widths of cmd_t come from burst_seq_pkg; the width parameters
// below must match it.
module burst_sequencer
    import burst_seq_pkg::*;
#(
    parameter int TIME_W    = CMD_TIME_W,
    parameter int FREQ_W    = CMD_FREQ_W,
    parameter int RATE_W    = CMD_RATE_W,
    parameter int IVL_W     = CMD_IVL_W,
    parameter int NIMP_W    = CMD_NIMP_W,
    parameter int DEPTH     = 8,
    parameter int LATE_EXEC = 0
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [TIME_W-1:0]      TIME,
    input  logic                   TIME_VALID,
    input  logic                   ABORT,
    input  logic                   CMD_WR,
    input  logic [TIME_W-1:0]      CMD_START,
    input  logic [FREQ_W-1:0]      CMD_FREQ,
    input  logic [FREQ_W-1:0]      CMD_DFREQ,
    input  logic [RATE_W-1:0]      CMD_RATE,
    input  logic [NIMP_W-1:0]      CMD_NIMP,
    input  logic                   CMD_COH,
    input  logic [IVL_W-1:0]       CMD_TB1,
    input  logic [IVL_W-1:0]       CMD_TI,
    input  logic [IVL_W-1:0]       CMD_TB2,
    input  logic [IVL_W-1:0]       CMD_TP,
    output logic                   CMD_FULL,
    output logic [$clog2(DEPTH):0] CMD_LEVEL,
    output logic                   CMD_OVF,
    output logic                   REQ,
    input  logic                   ACK,
    output logic [FREQ_W-1:0]      DDS_freq,
    output logic [FREQ_W-1:0]      DDS_delta_freq,
    output logic [RATE_W-1:0]      DDS_delta_rate,
    output logic                   DDS_start,
    output logic                   En_Iz,
    output logic                   En_Pr,
    output logic                   BUSY,
    output logic                   CMD_DONE,
    output logic                   CMD_LATE,
    output logic                   REQ_COMMAND
);
    state_t             state, state_n;
    cmd_t               cmd_q, cmd_n, fifo_wdata, fifo_rdata;
    logic               fifo_empty, pop;
    logic               first_q, first_n;
    logic [IVL_W-1:0]   cnt_q, cnt_n;
    logic               req_n, ds_n, done_n, late_n, reqcmd_n;
    logic [FREQ_W-1:0]  freq_n, dfreq_n;
    logic [RATE_W-1:0]  rate_n;
    logic               last;

    assign fifo_wdata = '{start: CMD_START, freq: CMD_FREQ, dfreq: CMD_DFREQ,
                          rate: CMD_RATE, nimp: CMD_NIMP, coh: CMD_COH,
                          tb1: CMD_TB1, ti: CMD_TI, tb2: CMD_TB2, tp: CMD_TP};

    burst_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .flush (ABORT),
        .wr    (CMD_WR),
        .wdata (fifo_wdata),
        .rd    (pop),
        .rdata (fifo_rdata),
        .full  (CMD_FULL),
        .empty (fifo_empty),
        .level (CMD_LEVEL),
        .ovf   (CMD_OVF)
    );

    // cmd_q.nimp counts remaining pulses; it reads 1 during the final pulse.
    assign last  = (cmd_q.nimp == NIMP_W'(1));
    assign En_Iz = (state == S_TIZL);
    assign En_Pr = (state == S_TPR);
    assign BUSY  = (state != S_IDLE);

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_n  = state;
        cmd_n    = cmd_q;
        first_n  = first_q;
        cnt_n    = cnt_q;
        req_n    = REQ;
        ds_n     = DDS_start;
        freq_n   = DDS_freq;
        dfreq_n  = DDS_delta_freq;
        rate_n   = DDS_delta_rate;
        done_n   = 1'b0;
        late_n   = 1'b0;
        reqcmd_n = 1'b0;
        pop      = 1'b0;
        if (ABORT || (state != S_IDLE && !TIME_VALID)) begin
            // Burst is lost: quiet every output, FIFO handling is up to ABORT.
            state_n = S_IDLE;
            req_n   = 1'b0;
            ds_n    = 1'b0;
            freq_n  = '0;
            dfreq_n = '0;
            rate_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty && TIME_VALID) begin
                        pop      = 1'b1;
                        reqcmd_n = 1'b1;
                        cmd_n    = fifo_rdata;
                        first_n  = 1'b1;
                        if (fifo_rdata.nimp == '0)
                            done_n = 1'b1;
                        else if (TIME < fifo_rdata.start)
                            state_n = S_WAIT_T;
                        else if (TIME == fifo_rdata.start)
                            state_n = S_LOAD;
                        else begin
                            late_n = 1'b1;
                            if (LATE_EXEC != 0) state_n = S_LOAD;
                        end
                    end
                end
                // Magnitude compare so a jump in TIME cannot skip the start.
                S_WAIT_T: if (TIME >= cmd_q.start) state_n = S_LOAD;
                S_LOAD: begin
                    if (cmd_q.coh && !first_q) begin
                        state_n = S_BLANK1;
                        cnt_n   = ivl_load(cmd_q.tb1);
                    end else begin
                        freq_n  = cmd_q.freq;
                        dfreq_n = cmd_q.dfreq;
                        rate_n  = cmd_q.rate;
                        req_n   = 1'b1;
                        first_n = 1'b0;
                        state_n = S_ACKWAIT;
                    end
                end
                S_ACKWAIT: begin
                    if (REQ) begin
                        if (ACK) req_n = 1'b0;
                    end else if (!ACK) begin
                        state_n = S_BLANK1;
                        cnt_n   = ivl_load(cmd_q.tb1);
                    end
                end
                S_BLANK1: begin
                    if (cnt_q == '0) begin
                        state_n = S_TIZL;
                        cnt_n   = ivl_load(cmd_q.ti);
                        ds_n    = 1'b1;
                    end else cnt_n = cnt_q - 1'b1;
                end
                S_TIZL: begin
                    if (cnt_q == '0) begin
                        state_n = S_BLANK2;
                        cnt_n   = ivl_load(cmd_q.tb2);
                        if (!cmd_q.coh || last) ds_n = 1'b0;
                    end else cnt_n = cnt_q - 1'b1;
                end
                S_BLANK2: begin
                    if (cnt_q == '0) begin
                        state_n = S_TPR;
                        cnt_n   = ivl_load(cmd_q.tp);
                    end else cnt_n = cnt_q - 1'b1;
                end
                S_TPR: begin
                    if (cnt_q == '0) state_n = S_NEXT;
                    else             cnt_n   = cnt_q - 1'b1;
                end
                S_NEXT: begin
                    cmd_n.nimp = cmd_q.nimp - 1'b1;
                    if (last) begin
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else state_n = S_LOAD;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state          <= S_IDLE;
            cmd_q          <= '0;
            first_q        <= 1'b0;
            cnt_q          <= '0;
            REQ            <= 1'b0;
            DDS_start      <= 1'b0;
            DDS_freq       <= '0;
            DDS_delta_freq <= '0;
            DDS_delta_rate <= '0;
            CMD_DONE       <= 1'b0;
            CMD_LATE       <= 1'b0;
            REQ_COMMAND    <= 1'b0;
        end else begin
            state          <= state_n;
            cmd_q          <= cmd_n;
            first_q        <= first_n;
            cnt_q          <= cnt_n;
            REQ            <= req_n;
            DDS_start      <= ds_n;
            DDS_freq       <= freq_n;
            DDS_delta_freq <= dfreq_n;
            DDS_delta_rate <= rate_n;
            CMD_DONE       <= done_n;
            CMD_LATE       <= late_n;
            REQ_COMMAND    <= reqcmd_n;
        end
    end

endmodule

// File: tb/tb_burst_sequencer.sv
// Directed bench for burst_sequencer: FIFO vector table plus burst sequences.
module tb_burst_sequencer;
    import burst_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic        CLK = 1'b0;
    logic        RESET, TIME_VALID, ABORT, CMD_WR, CMD_COH, ACK, ACK2;
    logic [63:0] TIME, CMD_START;
    logic [47:0] CMD_FREQ, CMD_DFREQ;
    logic [31:0] CMD_RATE, CMD_TB1, CMD_TI, CMD_TB2, CMD_TP;
    logic [15:0] CMD_NIMP;

    logic          CMD_FULL, CMD_OVF, REQ, DDS_start, En_Iz, En_Pr, BUSY, CMD_DONE, CMD_LATE, REQ_COMMAND;
    logic [LW-1:0] CMD_LEVEL;
    logic [47:0]   DDS_freq, DDS_delta_freq;
    logic [31:0]   DDS_delta_rate;
    logic          l_CMD_FULL, l_CMD_OVF, l_REQ, l_DDS_start, l_En_Iz, l_En_Pr, l_BUSY, l_CMD_DONE, l_CMD_LATE, l_REQ_COMMAND;
    logic [LW-1:0] l_CMD_LEVEL;
    logic [47:0]   l_DDS_freq, l_DDS_delta_freq;
    logic [31:0]   l_DDS_delta_rate;

    always #5 CLK = ~CLK;

    burst_sequencer #(.DEPTH(DEPTH), .LATE_EXEC(0)) dut (
        .CLK(CLK), .RESET(RESET), .TIME(TIME), .TIME_VALID(TIME_VALID), .ABORT(ABORT),
        .CMD_WR(CMD_WR), .CMD_START(CMD_START), .CMD_FREQ(CMD_FREQ), .CMD_DFREQ(CMD_DFREQ),
        .CMD_RATE(CMD_RATE), .CMD_NIMP(CMD_NIMP), .CMD_COH(CMD_COH), .CMD_TB1(CMD_TB1),
        .CMD_TI(CMD_TI), .CMD_TB2(CMD_TB2), .CMD_TP(CMD_TP), .CMD_FULL(CMD_FULL),
        .CMD_LEVEL(CMD_LEVEL), .CMD_OVF(CMD_OVF), .REQ(REQ), .ACK(ACK), .DDS_freq(DDS_freq),
        .DDS_delta_freq(DDS_delta_freq), .DDS_delta_rate(DDS_delta_rate), .DDS_start(DDS_start),
        .En_Iz(En_Iz), .En_Pr(En_Pr), .BUSY(BUSY), .CMD_DONE(CMD_DONE), .CMD_LATE(CMD_LATE),
        .REQ_COMMAND(REQ_COMMAND)
    );

    burst_sequencer #(.DEPTH(DEPTH), .LATE_EXEC(1)) dut_late (
        .CLK(CLK), .RESET(RESET), .TIME(TIME), .TIME_VALID(TIME_VALID), .ABORT(ABORT),
        .CMD_WR(CMD_WR), .CMD_START(CMD_START), .CMD_FREQ(CMD_FREQ), .CMD_DFREQ(CMD_DFREQ),
        .CMD_RATE(CMD_RATE), .CMD_NIMP(CMD_NIMP), .CMD_COH(CMD_COH), .CMD_TB1(CMD_TB1),
        .CMD_TI(CMD_TI), .CMD_TB2(CMD_TB2), .CMD_TP(CMD_TP), .CMD_FULL(l_CMD_FULL),
        .CMD_LEVEL(l_CMD_LEVEL), .CMD_OVF(l_CMD_OVF), .REQ(l_REQ), .ACK(ACK2), .DDS_freq(l_DDS_freq),
        .DDS_delta_freq(l_DDS_delta_freq), .DDS_delta_rate(l_DDS_delta_rate), .DDS_start(l_DDS_start),
        .En_Iz(l_En_Iz), .En_Pr(l_En_Pr), .BUSY(l_BUSY), .CMD_DONE(l_CMD_DONE), .CMD_LATE(l_CMD_LATE),
        .REQ_COMMAND(l_REQ_COMMAND)
    );

    int n_chk = 0, n_err = 0;
    // Event monitor counters
    int n_req_rise, n_chg, n_iz, n_izbad, iz_len, iz_exp, n_pr, n_dsr, n_dsh, n_dspr;
    int n_done, n_late, n_rc, l_iz, l_done, l_late;
    longint first_t;
    logic [47:0] fq[$];
    logic p_req = 0, p_iz = 0, p_ds = 0, p_pr = 0, l_p_iz = 0;
    logic [47:0] p_freq = '0;
    logic auto_ack = 1'b1, ramp = 1'b0;

    typedef struct {
        logic wr, tv, ab;
        int   lvl;
        logic full, ovf, busy;
    } vec_t;
    vec_t vt[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_mon();
        n_req_rise = 0; n_chg = 0; n_iz = 0; n_izbad = 0; iz_len = 0; n_pr = 0;
        n_dsr = 0; n_dsh = 0; n_dspr = 0; n_done = 0; n_late = 0; n_rc = 0;
        l_iz = 0; l_done = 0; l_late = 0; first_t = -1;
        fq.delete();
    endtask

    // One clock: sample outputs after the edge, update monitors, answer REQ, advance TIME.
    task automatic step();
        @(posedge CLK); #1;
        if (REQ && !p_req) begin n_req_rise++; fq.push_back(DDS_freq); end
        if (REQ && p_req && DDS_freq != p_freq) n_chg++;
        if (En_Iz) begin
            iz_len++;
            if (!p_iz) begin n_iz++; if (first_t < 0) first_t = longint'(TIME); end
        end else if (p_iz) begin
            if (iz_len != iz_exp) n_izbad++;
            iz_len = 0;
        end
        if (En_Pr && !p_pr) n_pr++;
        if (DDS_start && !p_ds) n_dsr++;
        if (DDS_start) n_dsh++;
        if (DDS_start && En_Pr) n_dspr++;
        n_done += int'(CMD_DONE); n_late += int'(CMD_LATE); n_rc += int'(REQ_COMMAND);
        if (l_En_Iz && !l_p_iz) l_iz++;
        l_done += int'(l_CMD_DONE); l_late += int'(l_CMD_LATE);
        p_req = REQ; p_iz = En_Iz; p_ds = DDS_start; p_pr = En_Pr; p_freq = DDS_freq; l_p_iz = l_En_Iz;
        if (auto_ack) ACK = REQ;
        ACK2 = l_REQ;
        if (ramp) TIME = TIME + 1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; CMD_WR = 0; ABORT = 0; TIME_VALID = 1; ACK = 0; ACK2 = 0;
        auto_ack = 1'b1; ramp = 1'b0; TIME = '0;
        step(); step();
        RESET = 1'b0;
        clr_mon();
    endtask

    task automatic set_cmd(input logic [63:0] st, input logic [15:0] ni, input logic coh,
                           input logic [47:0] fr, input logic [31:0] ivl);
        CMD_START = st; CMD_NIMP = ni; CMD_COH = coh; CMD_FREQ = fr;
        CMD_DFREQ = fr + 48'd1; CMD_RATE = 32'd7;
        CMD_TB1 = ivl; CMD_TI = ivl; CMD_TB2 = ivl; CMD_TP = ivl;
    endtask

    task automatic push(input logic [63:0] st, input logic [15:0] ni, input logic coh,
                        input logic [47:0] fr, input logic [31:0] ivl);
        set_cmd(st, ni, coh, fr, ivl);
        CMD_WR = 1'b1; step(); CMD_WR = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int target, input int maxc);
        int k = 0;
        while (n_done < target && k < maxc) begin step(); k++; end
        chk(nm, 64'(n_done >= target), 64'd1);
    endtask

    task automatic burst_test(input logic coh);
        do_reset();
        ramp = 1; iz_exp = 10;
        push(64'd1000, 16'd3, coh, 48'h123456, 32'd10);
        wait_done(coh ? "coh_done_wait" : "inc_done_wait", 1, 3000);
        repeat (5) step();
        chk("burst_iz_runs", 64'(n_iz), 64'd3);
        chk("burst_iz_len", 64'(n_izbad), 64'd0);
        chk("burst_pr_runs", 64'(n_pr), 64'd3);
        chk("burst_done", 64'(n_done), 64'd1);
        chk("burst_first_iz_time", 64'(first_t), 64'd1013);
        chk("burst_data_stable", 64'(n_chg), 64'd0);
        if (!coh) begin
            chk("inc_handshakes", 64'(n_req_rise), 64'd3);
            chk("inc_ds_rises", 64'(n_dsr), 64'd3);
            chk("inc_ds_high", 64'(n_dsh), 64'd30);
            chk("inc_ds_in_tpr", 64'(n_dspr), 64'd0);
        end else begin
            chk("coh_handshakes", 64'(n_req_rise), 64'd1);
            chk("coh_ds_rises", 64'(n_dsr), 64'd1);
            chk("coh_ds_high", 64'(n_dsh), 64'd94);
            chk("coh_ds_in_tpr", 64'(n_dspr), 64'd20);
        end
    endtask

    initial begin
        int k, bad;
        CMD_WR = 0; ABORT = 0; TIME_VALID = 0; ACK = 0; ACK2 = 0; TIME = '0; iz_exp = 10;
        set_cmd(64'd0, 16'd0, 1'b0, 48'd0, 32'd0);
        do_reset();

        // Reset state
        chk("rst_ctl", 64'({REQ, DDS_start, En_Iz, En_Pr, BUSY, CMD_DONE, CMD_LATE, REQ_COMMAND, CMD_FULL, CMD_OVF}), 64'd0);
        chk("rst_level", 64'(CMD_LEVEL), 64'd0);
        chk("rst_dds", 64'(DDS_freq | DDS_delta_freq | 48'(DDS_delta_rate)), 64'd0);

        // Incoherent and coherent bursts
        burst_test(1'b0);
        burst_test(1'b1);

        // FIFO vector table: TIME frozen at 0, starts in the future
        for (int i = 0; i < 8; i++) vt[i] = '{1, 0, 0, i + 1, (i == 7), 0, 0};
        vt[8]  = '{1, 0, 0, 8, 1, 1, 0};  // push while full
        vt[9]  = '{0, 0, 0, 8, 1, 0, 0};
        vt[10] = '{1, 1, 0, 8, 1, 0, 1};  // pop frees space for same-cycle push
        vt[11] = '{0, 0, 0, 8, 1, 0, 0};  // TIME_VALID low drops the waiting burst
        vt[12] = '{0, 0, 1, 0, 0, 0, 0};  // abort flushes
        vt[13] = '{1, 0, 1, 0, 0, 0, 0};  // abort beats push
        vt[14] = '{1, 0, 0, 1, 0, 0, 0};
        do_reset();
        set_cmd(64'd1000, 16'd1, 1'b0, 48'h55, 32'd2);
        for (int i = 0; i < 15; i++) begin
            CMD_WR = vt[i].wr; TIME_VALID = vt[i].tv; ABORT = vt[i].ab;
            step();
            chk($sformatf("fifo_v%0d_level", i), 64'(CMD_LEVEL), 64'(vt[i].lvl));
            chk($sformatf("fifo_v%0d_full", i), 64'(CMD_FULL), 64'(vt[i].full));
            chk($sformatf("fifo_v%0d_ovf", i), 64'(CMD_OVF), 64'(vt[i].ovf));
            chk($sformatf("fifo_v%0d_busy", i), 64'(BUSY), 64'(vt[i].busy));
        end
        CMD_WR = 0; ABORT = 0; TIME_VALID = 1;

        // Commands execute in push order
        do_reset();
        ramp = 1; iz_exp = 2;
        push(64'd100, 16'd1, 1'b0, 48'h111, 32'd2);
        push(64'd200, 16'd1, 1'b0, 48'h222, 32'd2);
        push(64'd300, 16'd1, 1'b0, 48'h333, 32'd2);
        wait_done("order_done_wait", 3, 1000);
        chk("order_count", 64'(fq.size()), 64'd3);
        if (fq.size() == 3) begin
            chk("order_0", 64'(fq[0]), 64'h111);
            chk("order_1", 64'(fq[1]), 64'h222);
            chk("order_2", 64'(fq[2]), 64'h333);
        end

        // NIMP=0: consumed, done next cycle, no pulses
        do_reset();
        push(64'd5000, 16'd0, 1'b0, 48'h9, 32'd2);
        repeat (4) step();
        chk("nimp0_done", 64'(n_done), 64'd1);
        chk("nimp0_pop", 64'(n_rc), 64'd1);
        chk("nimp0_no_req", 64'(n_req_rise + n_iz), 64'd0);

        // TIME_VALID lost during emit
        do_reset();
        ramp = 1;
        push(64'd100, 16'd2, 1'b0, 48'h77, 32'd10);
        push(64'd100, 16'd2, 1'b0, 48'h78, 32'd10);
        k = 0;
        while (!En_Iz && k < 500) begin step(); k++; end
        chk("tv_iz_seen", 64'(En_Iz), 64'd1);
        TIME_VALID = 0;
        step();
        chk("tv_outs_zero", 64'({REQ, DDS_start, En_Iz, En_Pr, BUSY}), 64'd0);
        chk("tv_level_kept", 64'(CMD_LEVEL), 64'd1);
        repeat (20) step();
        chk("tv_no_done", 64'(n_done), 64'd0);
        ABORT = 1; step(); ABORT = 0;
        chk("abort_level", 64'(CMD_LEVEL), 64'd0);
        TIME_VALID = 1;

        // ACK held low: REQ and data stay put, BLANK1 only after ACK 1 then 0
        do_reset();
        ramp = 1; auto_ack = 0; ACK = 0;
        CMD_WR = 1; set_cmd(64'd50, 16'd1, 1'b0, 48'hABCDE, 32'd5); step(); CMD_WR = 0;
        k = 0;
        while (!REQ && k < 200) begin step(); k++; end
        chk("ack_req_seen", 64'(REQ), 64'd1);
        bad = 0;
        repeat (200) begin
            step();
            if (!REQ || DDS_freq != 48'hABCDE || En_Iz) bad++;
        end
        chk("ack_hold_stable", 64'(bad), 64'd0);
        chk("ack_hold_freq", 64'(DDS_freq), 64'hABCDE);
        ACK = 1; step();
        chk("ack_req_drop", 64'(REQ), 64'd0);
        bad = 0;
        repeat (10) begin step(); if (En_Iz) bad++; end
        chk("ack_high_no_emit", 64'(bad), 64'd0);
        ACK = 0;
        k = 0;
        while (!En_Iz && k < 50) begin step(); k++; end
        chk("ack_to_emit_cycles", 64'(k), 64'd6);
        // Reset in the middle of the burst
        RESET = 1; step(); RESET = 0;
        chk("midrst_ctl", 64'({REQ, DDS_start, En_Iz, En_Pr, BUSY, CMD_DONE}), 64'd0);
        chk("midrst_dds", 64'(DDS_freq), 64'd0);
        auto_ack = 1;

        // Late command: dropped by LATE_EXEC=0, executed by LATE_EXEC=1
        do_reset();
        TIME = 64'd600; ramp = 1; iz_exp = 2;
        push(64'd500, 16'd1, 1'b0, 48'h42, 32'd2);
        k = 0;
        while (l_done < 1 && k < 200) begin step(); k++; end
        chk("late_exec_done", 64'(l_done), 64'd1);
        chk("late_pulse_drop", 64'(n_late), 64'd1);
        chk("late_pulse_exec", 64'(l_late), 64'd1);
        chk("late_drop_no_emit", 64'(n_iz), 64'd0);
        chk("late_drop_no_done", 64'(n_done), 64'd0);
        chk("late_exec_emit", 64'(l_iz), 64'd1);
        chk("late_drop_idle", 64'({BUSY, CMD_LEVEL}), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/burst_sequencer.md
Name: burst_sequencer

Overview:
Time-triggered transmit/receive burst sequencer and parametrised successor of the single-command start block. It queues timed burst commands in an internal FIFO and starts each one when system time reaches its start stamp. Per pulse it sequences blank1 / emit / blank2 / receive, loads the DDS through a 4-phase REQ/ACK handshake, and reports late, done and overflow events. It sits between the real-time command register and dds_chirp, with TIME supplied by the system clock block.

Parameters:
TIME_W, 64, system time and start-stamp width (1/48 us ticks)
FREQ_W, 48, DDS frequency and delta-frequency width
RATE_W, 32, DDS rate width
IVL_W, 32, interval counter width
NIMP_W, 16, pulse-count width
DEPTH, 8, command FIFO depth (power of 2, >=2)
LATE_EXEC, 0, 0 = drop late command, 1 = execute late command immediately

Ports:
CLK  in  1  single clock, 48 MHz
RESET  in  1  synchronous, active-high
TIME  in  TIME_W  current system time
TIME_VALID  in  1  system time synchronised to T1hz
ABORT  in  1  flush FIFO, stop current burst
CMD_WR  in  1  push command (one cycle)
CMD_START  in  TIME_W  start time stamp
CMD_FREQ  in  FREQ_W  DDS start frequency
CMD_DFREQ  in  FREQ_W  DDS frequency step
CMD_RATE  in  RATE_W  DDS step rate
CMD_NIMP  in  NIMP_W  pulses in burst
CMD_COH  in  1  1 = coherent (DDS loaded once per burst)
CMD_TB1, CMD_TI, CMD_TB2, CMD_TP  in  IVL_W each  blank1, emit, blank2, receive intervals
CMD_FULL  out  1  FIFO full
CMD_LEVEL  out  $clog2(DEPTH)+1  FIFO occupancy
CMD_OVF  out  1  one-cycle pulse: push while full
REQ  out  1  DDS data request
ACK  in  1  DDS data acknowledge
DDS_freq / DDS_delta_freq / DDS_delta_rate  out  FREQ_W / FREQ_W / RATE_W  DDS data, stable while REQ=1
DDS_start  out  1  DDS run
En_Iz  out  1  emit enable
En_Pr  out  1  receive enable
BUSY  out  1  state is not IDLE
CMD_DONE  out  1  one-cycle pulse at burst end
CMD_LATE  out  1  one-cycle pulse: start stamp already passed at pop
REQ_COMMAND  out  1  one-cycle pulse on each FIFO pop

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, DDS data registers 0.
- States: IDLE, WAIT_T, LOAD, ACKWAIT, BLANK1, TIZL, BLANK2, TPR, NEXT.
- IDLE: if FIFO not empty and TIME_VALID, pop to the working registers, pulse REQ_COMMAND, then:
  - TIME < start: go to WAIT_T.
  - TIME == start: go to LOAD.
  - TIME > start: pulse CMD_LATE; LATE_EXEC=1 goes to LOAD, LATE_EXEC=0 drops the command and stays in IDLE.
- NIMP=0: command consumed, CMD_DONE pulses the next cycle, no pulses emitted.
- WAIT_T: compare TIME >= start (never ==, so time jumps cannot hang the block); go to LOAD.
- LOAD: skipped to BLANK1 when the burst is coherent and this is not its first pulse. Otherwise latch DDS data and set REQ=1, then go to ACKWAIT.
- ACKWAIT: on ACK=1 drop REQ; on ACK=0 after that, go to BLANK1. DDS data must not change while REQ=1.
- Intervals: an interval value N lasts exactly N cycles; N=0 is treated as 1. The down-counter is loaded on state entry.
- TIZL: DDS_start=1, En_Iz=1. BLANK2: En_Iz=0. TPR: En_Pr=1.
- DDS_start in BLANK2: cleared in incoherent mode, or on the last pulse. In coherent mode it stays 1 across all pulses of the burst.
- NEXT: En_Pr=0, decrement the remaining-pulse count. If more pulses remain go to LOAD; otherwise pulse CMD_DONE and go to IDLE.
- Back-to-back bursts: the next command may be popped the cycle after NEXT.
- FIFO:
  - Push and pop in the same cycle are both honoured, level unchanged.
  - Push while full is discarded and pulses CMD_OVF; a pop in the same cycle frees space first.
  - Pointers wrap modulo DEPTH.
- TIME_VALID falling while BUSY: go to IDLE next cycle, outputs 0, burst lost, no CMD_DONE, FIFO retained.
- ABORT: go to IDLE next cycle with all outputs 0 and FIFO emptied. ABORT has priority over CMD_WR in the same cycle.
- Reset mid-burst: identical to the reset values above.

Decomposition:
- burst_seq_pkg: cmd_t packed struct (all CMD_* fields), state_t enum, widths as localparams derived from the parameters.
- One sub-module, burst_cmd_fifo: synchronous FIFO of cmd_t, parametrised DEPTH, with full, empty, level and ovf outputs.

Test Plan:
- One command, start=1000, NIMP=3, TB1=TI=TB2=TP=10, COH=0, TIME ramping from 0 -> 3 REQ/ACK handshakes; En_Iz high for exactly 10 cycles per pulse; DDS_start low in each BLANK2; CMD_DONE once.
- Same command with COH=1 -> one handshake only; DDS_start high continuously from the first TIZL to the last BLANK2.
- Start=500 pushed with TIME=600: LATE_EXEC=0 -> CMD_LATE pulse, no pulses emitted. LATE_EXEC=1 -> CMD_LATE pulse, then the burst runs.
- DEPTH=8, 9 pushes -> CMD_FULL asserted after 8; 9th push gives CMD_OVF pulse; CMD_LEVEL=8; commands execute in push order.
- TIME_VALID dropped during TIZL -> all outputs 0 next cycle, no CMD_DONE, CMD_LEVEL unchanged. ABORT -> CMD_LEVEL=0.
- ACK held low for 200 cycles -> REQ stays 1 with stable data; BLANK1 starts only after ACK goes 1 then 0.
